// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared calc1 command/response codes, bus widths and requester state encoding
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_OVF  = 2'd2;
    localparam logic [RESP_W-1:0] RESP_INV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND1     = 3'd1,
        ST_SEND2     = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/calc1_port_requester_if.sv
// rtl/calc1_port_requester_if.sv - client handshake plus calc1 port signals of one requester
interface calc1_port_requester_if;
    import calc1_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_op;
    logic [DATA_W-1:0] cmd_op1;
    logic [DATA_W-1:0] cmd_op2;

    logic [CMD_W-1:0]  req_cmd_out;
    logic [DATA_W-1:0] req_data_out;
    logic [RESP_W-1:0] out_resp;
    logic [DATA_W-1:0] out_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RESP_W-1:0] rsp_resp;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic              spurious_resp;

    // Requester side
    modport slave (
        input  cmd_valid, cmd_op, cmd_op1, cmd_op2,
        input  out_resp, out_data,
        input  rsp_ready,
        output cmd_ready,
        output req_cmd_out, req_data_out,
        output rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious_resp
    );

    // Client and calc1 side
    modport master (
        output cmd_valid, cmd_op, cmd_op1, cmd_op2,
        output out_resp, out_data,
        output rsp_ready,
        input  cmd_ready,
        input  req_cmd_out, req_data_out,
        input  rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious_resp
    );

endinterface

// File: rtl/calc1_port_requester.sv
// rtl/calc1_port_requester.sv - serialises one client operation onto a calc1 port and returns its response
module calc1_port_requester
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic                   c_clk,
    input  logic                   reset,
    calc1_port_requester_if.slave  bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [DATA_W-1:0] op2_q,         op2_d;
    logic [CMD_W-1:0]  req_cmd_q,     req_cmd_d;
    logic [DATA_W-1:0] req_data_q,    req_data_d;
    logic [RESP_W-1:0] rsp_resp_q,    rsp_resp_d;
    logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              spurious_q,    spurious_d;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op2_q         <= '0;
            req_cmd_q     <= CMD_NOP;
            req_data_q    <= '0;
            rsp_resp_q    <= RESP_NONE;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op2_q         <= op2_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            spurious_q    <= spurious_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op2_d         = op2_q;
        req_cmd_d     = req_cmd_q;
        req_data_d    = req_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        spurious_d    = spurious_q;

        // Any response outside the wait window is not ours (e.g. left over from before a reset)
        if ((state_q != ST_WAIT_RESP) && (bus.out_resp != RESP_NONE)) begin
            spurious_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    req_cmd_d  = bus.cmd_op;
                    req_data_d = bus.cmd_op1;
                    op2_d      = bus.cmd_op2;
                    state_d    = ST_SEND1;
                end
            end
            ST_SEND1: begin
                req_cmd_d  = CMD_NOP;
                req_data_d = op2_q;
                state_d    = ST_SEND2;
            end
            ST_SEND2: begin
                req_cmd_d  = CMD_NOP;
                req_data_d = '0;
                cnt_d      = '0;
                state_d    = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response beats the timeout when both land on the same cycle
                if (bus.out_resp != RESP_NONE) begin
                    rsp_resp_d    = bus.out_resp;
                    rsp_data_d    = bus.out_data;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_resp_d    = RESP_NONE;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = (state_q == ST_DONE);
    assign bus.req_cmd_out   = req_cmd_q;
    assign bus.req_data_out  = req_data_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.spurious_resp = spurious_q;

endmodule

// File: tb/tb_calc1_port_requester.sv
// tb/tb_calc1_port_requester.sv - scoreboard bench for calc1_port_requester with a behavioural calc1 port
module tb_calc1_port_requester;
    import calc1_pkg::*;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    calc1_port_requester_if bus();

    calc1_port_requester #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (10)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    // Reference calc1 behaviour for the codes the bench uses
    function automatic exp_t calc_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.tmo = 1'b0;
        case (op)
            CMD_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.data = s[31:0];
                e.resp = s[32] ? RESP_OVF : RESP_OK;
            end
            CMD_SUB: begin
                e.data = a - b;
                e.resp = (a < b) ? RESP_OVF : RESP_OK;
            end
            CMD_SHL: begin e.data = a << b[4:0]; e.resp = RESP_OK; end
            CMD_SHR: begin e.data = a >> b[4:0]; e.resp = RESP_OK; end
            default: begin e.data = 32'd0; e.resp = RESP_INV; end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin
            @(posedge c_clk); #1;
            k++;
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_op1   = a;
        bus.cmd_op2   = b;
        @(posedge c_clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'hF;
        bus.cmd_op1   = 32'hDEAD_BEEF;
        bus.cmd_op2   = 32'hCAFE_F00D;
        n_checks++;
        if (bus.req_cmd_out !== op || bus.req_data_out !== a || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL send1: cmd=%0d data=%h ready=%b required cmd=%0d data=%h ready=0",
                     bus.req_cmd_out, bus.req_data_out, bus.cmd_ready, op, a);
        end
        @(posedge c_clk); #1;
        n_checks++;
        if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== b || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL send2: cmd=%0d data=%h ready=%b required cmd=0 data=%h ready=0",
                     bus.req_cmd_out, bus.req_data_out, bus.cmd_ready, b);
        end
        @(posedge c_clk); #1;
        n_checks++;
        if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: cmd=%0d data=%h rsp_valid=%b required 0/0/0",
                     bus.req_cmd_out, bus.req_data_out, bus.rsp_valid);
        end
    endtask

    // Called at the first WAIT_RESP cycle; answers after d further cycles
    task automatic respond_after(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = calc_ref(op, a, b);
        repeat (d) begin
            @(posedge c_clk); #1;
            n_checks++;
            if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_busy: cmd_ready=%b rsp_valid=%b required 0/0", bus.cmd_ready, bus.rsp_valid);
            end
        end
        bus.out_resp = e.resp;
        bus.out_data = e.data;
        sb.push_back(e);
        @(posedge c_clk); #1;
        bus.out_resp = 2'd0;
        bus.out_data = 32'd0;
    endtask

    task automatic collect(input string name);
        int   k;
        exp_t e;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 50) begin
            @(posedge c_clk); #1;
            k++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: rsp_valid=%b required 1 within 50 cycles", name, bus.rsp_valid);
            return;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: response with empty scoreboard, got resp=%0d required none", name, bus.rsp_resp);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.rsp_resp !== e.resp || bus.rsp_data !== e.data || bus.rsp_timeout !== e.tmo) begin
                n_fail++;
                $display("FAIL %s_result: resp=%0d data=%h tmo=%b required resp=%0d data=%h tmo=%b",
                         name, bus.rsp_resp, bus.rsp_data, bus.rsp_timeout, e.resp, e.data, e.tmo);
            end
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_ready: cmd_ready=%b required 0", name, bus.cmd_ready);
        end
        bus.rsp_ready = 1'b1;
        @(posedge c_clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: rsp_valid=%b cmd_ready=%b required 0/1", name, bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_cmd_out !== 4'd0 ||
            bus.req_data_out !== 32'd0 || bus.rsp_resp !== 2'd0 || bus.rsp_data !== 32'd0 ||
            bus.rsp_timeout !== 1'b0 || bus.spurious_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: ready=%b valid=%b cmd=%0d data=%h resp=%0d rdata=%h tmo=%b spur=%b required 1/0/0/0/0/0/0/0",
                     name, bus.cmd_ready, bus.rsp_valid, bus.req_cmd_out, bus.req_data_out,
                     bus.rsp_resp, bus.rsp_data, bus.rsp_timeout, bus.spurious_resp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge c_clk);
        #1;
        check_reset_values("reset_hold");
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk); #1;
        check_reset_values("reset_release");
    endtask

    task automatic test_add();
        issue(CMD_ADD, 32'd5, 32'd7);
        respond_after(3, CMD_ADD, 32'd5, 32'd7);
        collect("add");
        issue(CMD_SHL, 32'd1, 32'd4);
        respond_after(0, CMD_SHL, 32'd1, 32'd4);
        collect("shl_min_latency");
        issue(CMD_ADD, 32'hFFFF_FFFF, 32'd2);
        respond_after(2, CMD_ADD, 32'hFFFF_FFFF, 32'd2);
        collect("add_ovf");
        n_checks++;
        if (bus.spurious_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL add_no_spurious: spurious_resp=%b required 0", bus.spurious_resp);
        end
    endtask

    task automatic test_errors();
        issue(CMD_SUB, 32'd3, 32'd5);
        respond_after(2, CMD_SUB, 32'd3, 32'd5);
        collect("sub_underflow");
        issue(4'd3, 32'd1, 32'd2);
        respond_after(1, 4'd3, 32'd1, 32'd2);
        collect("invalid_cmd");
    endtask

    task automatic test_timeout();
        exp_t e;
        issue(CMD_ADD, 32'd9, 32'd9);
        repeat (7) @(posedge c_clk);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: rsp_valid=%b after 7 wait cycles required 0", bus.rsp_valid);
        end
        e.resp = 2'd0;
        e.data = 32'd0;
        e.tmo  = 1'b1;
        sb.push_back(e);
        @(posedge c_clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_exact: rsp_valid=%b after 8 wait cycles required 1", bus.rsp_valid);
        end
        collect("timeout");
    endtask

    task automatic test_resp_vs_timeout();
        issue(CMD_SUB, 32'd50, 32'd8);
        respond_after(7, CMD_SUB, 32'd50, 32'd8);
        collect("resp_wins");
    endtask

    task automatic test_hold_done();
        exp_t e;
        e = calc_ref(CMD_ADD, 32'd100, 32'd23);
        issue(CMD_ADD, 32'd100, 32'd23);
        respond_after(1, CMD_ADD, 32'd100, 32'd23);
        n_checks++;
        if (bus.spurious_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_spur_before: spurious_resp=%b required 0", bus.spurious_resp);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.out_resp = 2'd1;
                bus.out_data = 32'h1234_5678;
            end else begin
                bus.out_resp = 2'd0;
                bus.out_data = 32'd0;
            end
            @(posedge c_clk); #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== e.resp || bus.rsp_data !== e.data) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: valid=%b resp=%0d data=%h required 1/%0d/%h",
                         i, bus.rsp_valid, bus.rsp_resp, bus.rsp_data, e.resp, e.data);
            end
        end
        n_checks++;
        if (bus.spurious_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_spur_after: spurious_resp=%b required 1", bus.spurious_resp);
        end
        collect("hold");
    endtask

    task automatic test_mid_reset();
        issue(CMD_ADD, 32'd4, 32'd4);
        repeat (2) @(posedge c_clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("midreset_async");
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk); #1;
        bus.out_resp = 2'd1;
        bus.out_data = 32'd8;
        @(posedge c_clk); #1;
        bus.out_resp = 2'd0;
        bus.out_data = 32'd0;
        n_checks++;
        if (bus.spurious_resp !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_resp: spurious=%b rsp_valid=%b required 1/0", bus.spurious_resp, bus.rsp_valid);
        end
        issue(CMD_ADD, 32'd1, 32'd1);
        respond_after(2, CMD_ADD, 32'd1, 32'd1);
        collect("after_reset_add");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_op1   = 32'd0;
        bus.cmd_op2   = 32'd0;
        bus.out_resp  = 2'd0;
        bus.out_data  = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_errors();
        test_timeout();
        test_resp_vs_timeout();
        test_hold_done();
        test_mid_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected responses left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc1_port_requester.md
Name: calc1_port_requester

Overview:
- Initiator for one calc1 request/response port: the active driver side of the calc1 interface.
- Accepts one operation from a local client over a valid/ready handshake.
- Serialises it onto a calc1 port as cmd+operand1, then operand2.
- Waits for the port's response, then returns resp code and data to the client.
- One instance per calc1 port (four per calc1), used both in the verification environment and by on-chip clients.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in WAIT_RESP before a timeout completion (legal range 4..1023)
CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
c_clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  client operation valid
cmd_ready  output  1  requester can accept an operation
cmd_op  input  4  calc1 command code (1 add, 2 sub, 5 shl, 6 shr; other codes passed through unchecked)
cmd_op1  input  32  operand 1
cmd_op2  input  32  operand 2
req_cmd_out  output  4  to calc1 reqN_cmd_in
req_data_out  output  32  to calc1 reqN_data_in
out_resp  input  2  from calc1 out_respN (0 none, 1 ok, 2 overflow/underflow, 3 invalid cmd)
out_data  input  32  from calc1 out_dataN
rsp_valid  output  1  result available
rsp_ready  input  1  client takes result
rsp_resp  output  2  captured calc1 resp code
rsp_data  output  32  captured calc1 result data
rsp_timeout  output  1  completion was a timeout
spurious_resp  output  1  sticky: nonzero out_resp seen outside WAIT_RESP

Behaviour:
- Reset (reset=0, async):
  - State=IDLE, counter=0.
  - cmd_ready=1; req_cmd_out=0; req_data_out=0.
  - rsp_valid=0; rsp_resp=0; rsp_data=0; rsp_timeout=0; spurious_resp=0.
- All outputs are registered. cmd_ready and rsp_valid are decoded from the state register.
- Operand latching: on the cmd_valid&&cmd_ready edge, op, op1 and op2 are latched internally. Later client input changes have no effect.
- FSM:
  - IDLE:
    - cmd_ready=1.
    - On accept -> SEND1.
  - SEND1 (exactly 1 cycle):
    - req_cmd_out=op, req_data_out=op1.
    - -> SEND2.
  - SEND2 (exactly 1 cycle):
    - req_cmd_out=0, req_data_out=op2.
    - -> WAIT_RESP; counter cleared.
  - WAIT_RESP:
    - req_cmd_out=0, req_data_out=0; counter increments each cycle.
    - If out_resp!=0: capture rsp_resp=out_resp and rsp_data=out_data, rsp_timeout=0 -> DONE.
    - Else if counter==TIMEOUT_CYCLES-1: rsp_resp=0, rsp_data=0, rsp_timeout=1 -> DONE.
    - A response and the timeout in the same cycle: the response wins.
  - DONE:
    - rsp_valid=1; result registers are held stable.
    - On rsp_ready -> IDLE.
    - cmd_ready stays 0 until the next cycle, so there is no same-cycle turnaround.
- Minimum accept-to-rsp_valid latency = 3 cycles plus calc1 latency.
- Throughput: at most one outstanding operation. calc1 must never see a second cmd before the first response.
- Nonzero out_resp in IDLE, SEND1, SEND2 or DONE sets spurious_resp (sticky until reset). It is otherwise ignored, and state is unaffected.
- Reset asserted mid-operation: immediate return to reset values. A late calc1 response after reset release is flagged as spurious.
- Command codes are not range-checked. calc1 reports invalid codes with resp 3, which is returned as-is.

Decomposition:
- Package calc1_pkg holds:
  - Command codes: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - Response codes: RESP_NONE=0, RESP_OK=1, RESP_OVF=2, RESP_INV=3.
  - The FSM state encoding.
- Single module; no sub-module is warranted. The timeout counter stays inline.

Test Plan:
1. Accept add op1=5, op2=7; calc1 model returns resp 1, data 12 four cycles after SEND2 -> req_cmd_out=1/req_data_out=5 in SEND1, 0/7 in SEND2; rsp_valid with rsp_resp=1, rsp_data=12, rsp_timeout=0.
2. Sub op1=3, op2=5 with model returning resp 2 -> rsp_resp=2, rsp_timeout=0. Op 3 with model returning resp 3 -> rsp_resp=3. cmd_ready stays 0 throughout both operations.
3. TIMEOUT_CYCLES=8, model never responds -> rsp_valid exactly 8 cycles after entering WAIT_RESP; rsp_timeout=1, rsp_resp=0, rsp_data=0.
4. rsp_ready held 0 for 10 cycles in DONE, while out_resp pulses 1 -> rsp_data/rsp_resp stable, spurious_resp=1. After rsp_ready=1, IDLE follows and cmd_ready=1 the next cycle.
5. reset=0 asserted mid-WAIT_RESP (not clock-aligned) -> all outputs at reset values immediately. A later model response raises spurious_resp. A new add 1+1 then completes with rsp_data=2.
6. Response arriving on the same cycle the counter reaches TIMEOUT_CYCLES-1 -> rsp_timeout=0 and the response data is captured.
